// File: rtl/harvester_rr_if.sv
// Signal bundle between harvester_rr, the polled core array and the shared write sink.
// master = the harvester side, slave = cores plus sink (the testbench).
interface harvester_rr_if #(
    parameter int unsigned CORE_BITS = 8,
    parameter int unsigned CORES     = 32,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8
);
    logic                   enable;
    logic [CORES-1:0]       r_pending;
    logic [CORES-1:0]       r_req;
    logic [CORE_BITS-1:0]   cs;
    logic [WIDTH+DEPTH-1:0] r_data;
    logic                   r_valid;
    logic [DEPTH-1:0]       w_addr;
    logic [WIDTH-1:0]       w_data;
    logic                   we;
    logic                   w_ready;
    logic [31:0]            word_count;
    logic [15:0]            drop_count;

    modport master (
        input  enable, r_pending, r_data, r_valid, w_ready,
        output r_req, cs, w_addr, w_data, we, word_count, drop_count
    );

    modport slave (
        output enable, r_pending, r_data, r_valid, w_ready,
        input  r_req, cs, w_addr, w_data, we, word_count, drop_count
    );
endinterface

// File: rtl/harvester_rr.sv
// Round-robin collector of per-core FIFO words into a shared write port, with a
// credit-limited request issue, an output skid FIFO and word/drop statistics.
module harvester_rr #(
    parameter int unsigned CORE_BITS    = 8,
    parameter int unsigned CORES        = 32,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned CS_DELAY     = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic            clk,
    input logic            reset_n,
    harvester_rr_if.master bus
);
    localparam int unsigned NSLOT = 1 << CORE_BITS;
    localparam int unsigned RL    = READ_LATENCY;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned DW    = WIDTH + DEPTH;

    logic                 r_grant_vld;
    logic [CORE_BITS-1:0] r_grant_idx;
    logic [CORES-1:0]     r_grant_oh;
    logic [RL-1:0]        r_exp;
    logic [CORE_BITS-1:0] r_exp_idx [RL-1];
    logic [CORE_BITS-1:0] r_ptr;
    logic [CORE_BITS-1:0] r_cs;
    logic [DW-1:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [31:0]          r_words;
    logic [15:0]          r_drops;

    logic [RL-1:0]        w_stg_vld;
    logic [CORE_BITS-1:0] w_stg_idx [RL];
    logic [NSLOT-1:0]     w_inflight;
    logic [NSLOT-1:0]     w_elig;
    logic [CNT_W-1:0]     w_out;
    logic [CNT_W-1:0]     w_used;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_found;
    logic                 w_grant;
    logic [CORE_BITS:0]   w_cand;
    logic [CORE_BITS-1:0] w_win;
    logic [CORES-1:0]     w_win_oh;
    logic [DW-1:0]        w_head;

    // Stage 0 is the grant being presented on r_req; stage k is k cycles older.
    always_comb begin
        w_stg_vld    = {r_exp[RL-2:0], r_grant_vld};
        w_stg_idx[0] = r_grant_idx;
        for (int unsigned k = 1; k < RL; k++) begin
            w_stg_idx[k] = r_exp_idx[k-1];
        end
    end

    // Reads still short of their response cycle block re-grant and hold credit.
    always_comb begin
        w_inflight = '0;
        w_out      = '0;
        for (int unsigned k = 0; k < RL; k++) begin
            if (w_stg_vld[k]) begin
                w_inflight[w_stg_idx[k]] = 1'b1;
                w_out = w_out + CNT_W'(1);
            end
        end
    end

    assign w_push = r_exp[RL-1] & bus.r_valid;
    assign w_drop = ~r_exp[RL-1] & bus.r_valid;
    assign w_pop  = (r_count != '0) & bus.w_ready;
    assign w_used = r_count + CNT_W'(w_push) - CNT_W'(w_pop) + w_out;
    assign w_elig = NSLOT'(bus.r_pending) & ~w_inflight & {NSLOT{bus.enable}};

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned off = 1; off <= CORES; off++) begin
            w_cand = {1'b0, r_ptr} + (CORE_BITS+1)'(off);
            if (w_cand >= (CORE_BITS+1)'(CORES)) begin
                w_cand = w_cand - (CORE_BITS+1)'(CORES);
            end
            if (!w_found && w_elig[w_cand[CORE_BITS-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[CORE_BITS-1:0];
            end
        end
    end

    assign w_grant = w_found & (w_used < CNT_W'(FIFO_DEPTH));

    always_comb begin
        w_win_oh = '0;
        for (int unsigned i = 0; i < CORES; i++) begin
            w_win_oh[i] = (w_win == CORE_BITS'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_vld <= 1'b0;
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
            r_exp       <= '0;
            for (int unsigned k = 0; k < RL - 1; k++) begin
                r_exp_idx[k] <= '0;
            end
            r_ptr   <= CORE_BITS'(CORES - 1);
            r_cs    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_words <= '0;
            r_drops <= '0;
        end else begin
            r_grant_vld <= w_grant;
            r_grant_idx <= w_win;
            r_grant_oh  <= w_grant ? w_win_oh : '0;
            r_exp       <= w_stg_vld;
            for (int unsigned k = 0; k < RL - 1; k++) begin
                r_exp_idx[k] <= w_stg_idx[k];
            end
            if (w_grant) begin
                r_ptr <= w_win;
            end
            if (w_stg_vld[CS_DELAY-1]) begin
                r_cs <= w_stg_idx[CS_DELAY-1];
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + PTR_W'(1);
                r_words <= r_words + 32'd1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_drop && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.r_data;
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign bus.we         = (r_count != '0);
    assign bus.w_addr     = bus.we ? w_head[DW-1:WIDTH] : '0;
    assign bus.w_data     = bus.we ? w_head[WIDTH-1:0] : '0;
    assign bus.r_req      = r_grant_oh;
    assign bus.cs         = r_cs;
    assign bus.word_count = r_words;
    assign bus.drop_count = r_drops;
endmodule

// File: tb/tb_harvester_rr.sv
// Randomised bench for harvester_rr: the bench plays the core array and the write sink,
// predicts grants from the arbitration rules and scoreboards every written word.
module tb_harvester_rr;
    localparam int unsigned CORE_BITS    = 8;
    localparam int unsigned CORES        = 32;
    localparam int unsigned WIDTH        = 32;
    localparam int unsigned DEPTH        = 8;
    localparam int unsigned READ_LATENCY = 3;
    localparam int unsigned CS_DELAY     = 2;
    localparam int unsigned FIFO_DEPTH   = 4;

    typedef logic [WIDTH+DEPTH-1:0] word_t;
    typedef struct {
        int core;
        int t;
    } grant_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    harvester_rr_if #(
        .CORE_BITS(CORE_BITS), .CORES(CORES), .WIDTH(WIDTH), .DEPTH(DEPTH)
    ) bus ();

    harvester_rr #(
        .CORE_BITS(CORE_BITS), .CORES(CORES), .WIDTH(WIDTH), .DEPTH(DEPTH),
        .READ_LATENCY(READ_LATENCY), .CS_DELAY(CS_DELAY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Reference state: outstanding grants, expected writes, statistics, core contents.
    grant_t      grants[$];
    word_t       exp_q[$];
    int          m_ptr;
    int          m_occ;
    int          m_cs;
    logic [31:0] m_words;
    int          m_drops;
    int          avail[CORES];
    int          cyc;
    int          n_cmp;
    int          n_fail;

    int          p_pend;
    int          p_ready;
    int          p_en;
    int          p_drop;
    int          p_spur;
    bit          force_en;
    word_t       force_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        grants.delete();
        exp_q.delete();
        m_ptr   = CORES - 1;
        m_occ   = 0;
        m_cs    = 0;
        m_words = '0;
        m_drops = 0;
    endtask

    task automatic clear_cores();
        for (int i = 0; i < CORES; i++) avail[i] = 0;
    endtask

    // One cycle, entered #1 after the rising edge.
    task automatic step();
        logic [CORES-1:0] exp_req;
        logic [CORES-1:0] pend;
        bit               busy[CORES];
        int               due;
        bit               valid;
        bit               push;
        bit               pop;
        bit               drop;
        bit               en;
        bit               rdy;
        word_t            data;

        exp_req = '0;
        due = -1;
        foreach (grants[i]) begin
            if (grants[i].t == cyc) exp_req[grants[i].core] = 1'b1;
            if (grants[i].t + int'(CS_DELAY) == cyc) m_cs = grants[i].core;
            if (grants[i].t + int'(READ_LATENCY) == cyc) due = i;
        end
        check("r_req", 64'(bus.r_req), 64'(exp_req));
        check("cs", 64'(bus.cs), 64'(m_cs));
        check("we", 64'(bus.we), 64'(m_occ != 0));
        check("word_count", 64'(bus.word_count), 64'(m_words));
        check("drop_count", 64'(bus.drop_count), 64'(m_drops));

        valid = 1'b0;
        push  = 1'b0;
        drop  = 1'b0;
        data  = word_t'({$urandom, $urandom});
        if (due >= 0) begin
            if (avail[grants[due].core] > 0) begin
                avail[grants[due].core]--;
                if (force_en) data = force_word;
                valid = 1'b1;
                push  = 1'b1;
                exp_q.push_back(data);
            end
            grants.delete(due);
        end else if ($urandom_range(99) < p_drop) begin
            valid = 1'b1;
            drop  = 1'b1;
        end

        for (int i = 0; i < CORES; i++) begin
            if ($urandom_range(999) < p_pend) avail[i]++;
            pend[i] = (avail[i] > 0) || ($urandom_range(99) < p_spur);
        end
        en  = ($urandom_range(99) < p_en);
        rdy = ($urandom_range(99) < p_ready);

        bus.r_valid   = valid;
        bus.r_data    = data;
        bus.r_pending = pend;
        bus.enable    = en;
        bus.w_ready   = rdy;

        pop = (m_occ > 0) && rdy;
        if (pop) m_words++;
        m_occ = m_occ + int'(push) - int'(pop);
        if (drop && m_drops < 65535) m_drops++;

        // Every grant still listed has not reached its response cycle: in flight and holding credit.
        foreach (busy[i]) busy[i] = 1'b0;
        foreach (grants[i]) busy[grants[i].core] = 1'b1;
        if (en && (m_occ + grants.size() < FIFO_DEPTH)) begin
            for (int k = 1; k <= CORES; k++) begin
                int c;
                c = (m_ptr + k) % CORES;
                if (pend[c] && !busy[c]) begin
                    grants.push_back('{core: c, t: cyc + 1});
                    m_ptr = c;
                    break;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        check("rst_we", 64'(bus.we), 64'(0));
        check("rst_w_addr", 64'(bus.w_addr), 64'(0));
        check("rst_w_data", 64'(bus.w_data), 64'(0));
        check("rst_r_req", 64'(bus.r_req), 64'(0));
        check("rst_word_count", 64'(bus.word_count), 64'(0));
        model_reset();
        bus.r_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
    endtask

    // Monitor: every accepted write must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_n && bus.we && bus.w_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL write_unexpected cyc=%0d got=%h want=none", cyc,
                         {bus.w_addr, bus.w_data});
            end else begin
                check("write_word", 64'({bus.w_addr, bus.w_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        bus.enable = 1'b0;
        bus.r_pending = '0;
        bus.r_valid = 1'b0;
        bus.r_data = '0;
        bus.w_ready = 1'b0;
        p_pend = 0; p_ready = 100; p_en = 100; p_drop = 0; p_spur = 0;
        force_en = 1'b0;
        force_word = {8'h12, 32'hDEADBEEF};
        model_reset();
        clear_cores();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Cores 0 and 2 pending: alternating grants with the response READ_LATENCY later.
        avail[0] = 40;
        avail[2] = 40;
        run(40);

        // Single word from core 5.
        clear_cores();
        mid_reset();
        avail[5] = 1;
        force_en = 1'b1;
        run(10);
        force_en = 1'b0;

        // Every core pending with the sink stalled: credit caps issue, then drain resumes.
        for (int i = 0; i < CORES; i++) avail[i] = 2;
        p_ready = 0;
        run(20);
        p_ready = 100;
        run(120);

        // Pointer starts at CORES-1 with only core 0 pending: wrap and no early re-grant.
        clear_cores();
        mid_reset();
        avail[0] = 4;
        run(25);

        // Randomised traffic with hints, drops, enable gaps and back-pressure.
        p_pend = 15; p_ready = 70; p_en = 85; p_drop = 3; p_spur = 5;
        run(3000);

        // Reset mid-stream with the FIFO stuffed, then a stale response arrives.
        p_ready = 0;
        run(10);
        mid_reset();
        p_drop = 100;
        run(1);
        p_drop = 3; p_ready = 70;
        run(500);

        // Drain, then hammer with stray responses until the drop counter saturates.
        clear_cores();
        p_pend = 0; p_en = 0; p_spur = 0; p_ready = 100; p_drop = 0;
        run(20);
        p_drop = 100;
        run(65540);
        p_drop = 0;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/harvester_rr.md
Name: harvester_rr

Overview:
- Next-generation collector of slave-to-master FIFO words from a many-core array into a shared write port (memory or register file).
- Polls only cores that flag pending data, using round-robin arbitration instead of blind rotation.
- Read latency and core-select delay are parametrised.
- Adds an output skid FIFO with write back-pressure, credit-limited request issue, and word/drop statistics.

Parameters:
- CORE_BITS, 8, width of core index (2**CORE_BITS >= CORES).
- CORES, 32, number of polled cores.
- WIDTH, 32, data word width.
- DEPTH, 8, write address width; each returned word is {addr[DEPTH], data[WIDTH]}.
- READ_LATENCY, 3, cycles from the r_req pulse to the matching r_valid/r_data (>= 2).
- CS_DELAY, 2, cycles from the r_req pulse to cs showing the granted core (1 <= CS_DELAY < READ_LATENCY).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  when low, no new grants; in-flight reads and FIFO still drain.
- r_pending  in  CORES  per-core FIFO non-empty hint.
- r_req  out  CORES  one-hot read-request pulse to the granted core.
- cs  out  CORE_BITS  read-data mux select.
- r_data  in  WIDTH+DEPTH  returned {addr, data}.
- r_valid  in  1  r_data valid.
- w_addr  out  DEPTH  write address (FIFO head).
- w_data  out  WIDTH  write data (FIFO head).
- we  out  1  write valid.
- w_ready  in  1  sink accepts; a transfer occurs when we && w_ready.
- word_count  out  32  transfers completed, wraps.
- drop_count  out  16  unexpected r_valid count, saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous) sets r_req=0, cs=0, we=0, w_addr=0, w_data=0, word_count=0, drop_count=0, round-robin pointer=CORES-1, FIFO empty, in-flight tracking cleared. Reset mid-operation discards all in-flight reads and FIFO contents.
- Eligible core i: r_pending[i] && !inflight[i] && enable. inflight[i] is set on grant and cleared READ_LATENCY cycles later. A core is never re-granted while its read is in flight.
- Credit: a grant is allowed only if (FIFO occupancy + in-flight count) < FIFO_DEPTH, counting a same-cycle pop. This guarantees no overflow.
- Arbiter: at most one grant per cycle. Search starts at pointer+1 modulo CORES, wrapping from CORES-1 to 0. The first eligible core wins, and the pointer moves to the winner. With no eligible core there is no grant and the pointer is held.
- Grant of core g registered at cycle t:
  - r_req = one-hot(g) during cycle t only.
  - cs = g from cycle t+CS_DELAY; it changes only when the next grant's delayed index arrives.
  - An expect bit travels a READ_LATENCY-deep shift line.
- Capture:
  - r_valid with expect bit set pushes r_data into the FIFO.
  - Expect bit set with r_valid=0 means the core was empty: nothing is pushed and the credit is released.
  - r_valid with expect bit clear is dropped and drop_count increments (saturating).
- Output: we = FIFO non-empty; w_addr/w_data = head, split {addr, data}, stable while we && !w_ready.
  - Pop plus push in the same cycle is legal. A full FIFO is unreachable by construction.
  - First-word latency: grant at t -> push at t+READ_LATENCY -> we high at t+READ_LATENCY+1.
- word_count increments on each we && w_ready, wrapping 0xFFFFFFFF -> 0.
- With enable low, no grants are made; outstanding reads complete normally.

Test Plan:
- Reset, then r_pending=0x0000_0005 held, w_ready=1, r_valid driven READ_LATENCY after each r_req -> grants alternate core 0, core 2, 0, 2; r_req is one-hot for 1 cycle; cs follows CS_DELAY cycles later.
- Single grant to core 5 at cycle t with r_data={8'h12,32'hDEADBEEF} returned at t+3 -> we=1 at t+4, w_addr=0x12, w_data=0xDEADBEEF, word_count=1.
- All 32 cores pending, w_ready=0 -> exactly 4 grants then no r_req; raise w_ready -> 4 writes in order, then grants resume with no loss or duplication.
- Pointer at core 31 with only core 0 pending -> grant wraps to core 0; core 0 is not re-granted until 3 cycles have passed.
- r_valid pulsed with no outstanding request -> nothing is written, drop_count=1; 0x10000 such pulses leave drop_count at 0xFFFF.
- Assert reset_n low mid-stream with 2 reads in flight and 2 words queued -> we=0 immediately, counters 0, late r_valid counts as a drop, and the next grant goes to the lowest-index pending core.
